// File: rtl/alu_reg_pkg.sv
// -----------------------------------------------------------------------------
// alu_reg_pkg
// Shared definitions for the alu_reg_unit datapath leaf:
//   - DEFAULT_WIDTH : default data width of ALU operands/result and register
//   - alu_op_e      : 3-bit ALU operation codes (OC_ADD .. OC_AND)
// -----------------------------------------------------------------------------
package alu_reg_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        OC_ADD = 3'b000,
        OC_SUB = 3'b001,
        OC_MUL = 3'b010,
        OC_DIV = 3'b011,
        OC_NOT = 3'b100,
        OC_XOR = 3'b101,
        OC_OR  = 3'b110,
        OC_AND = 3'b111
    } alu_op_e;

endpackage : alu_reg_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational 8-operation ALU. All results are unsigned and truncated
// to WIDTH bits; there is no carry/flag output.
// Ports:
//   oc [2:0]       operation code (see alu_reg_pkg::alu_op_e)
//   a  [WIDTH-1:0] operand A
//   b  [WIDTH-1:0] operand B
//   f  [WIDTH-1:0] result, zero latency
// -----------------------------------------------------------------------------
module alu_core
    import alu_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       oc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        // NOTE: assigning a default before the case guarantees f is driven on
        // every path, so no latch can be inferred if the case is ever edited.
        f = '0;
        case (oc)
            OC_ADD: f = a + b;
            OC_SUB: f = a - b;
            OC_MUL: f = a * b;   // result context is WIDTH bits: keeps low half
            // Divide by zero is defined as 0 so f is never X.
            OC_DIV: f = (b == '0) ? '0 : a / b;
            OC_NOT: f = ~a;
            OC_XOR: f = a ^ b;
            OC_OR:  f = a | b;
            OC_AND: f = a & b;
            default: f = '0;
        endcase
    end

endmodule : alu_core

// File: rtl/alu_reg_unit.sv
// -----------------------------------------------------------------------------
// alu_reg_unit
// Datapath leaf holding two independent paths that share one boundary:
//   - a combinational ALU (alu_core), and
//   - a WIDTH-bit control register with clear/load/inc/dec/shift.
// The two paths are not connected internally; the surrounding datapath wires
// them together as needed.
// Ports:
//   clk            rising-edge clock (register only)
//   rst            synchronous active-high reset, clears the register
//   oc, a, b       ALU opcode and operands
//   f              ALU result (combinational)
//   cl, ld         register clear / parallel load (load data on in)
//   inc, dec       register increment / decrement (wrapping)
//   sr, ir         shift right, serial bit inserted at MSB
//   sl, il         shift left, serial bit inserted at LSB
//   out            register contents (direct flop output)
// Register control priority, highest first: rst, cl, ld, inc, dec, sr, sl.
// -----------------------------------------------------------------------------
module alu_reg_unit
    import alu_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       oc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    input  logic             cl,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             inc,
    input  logic             dec,
    input  logic             sr,
    input  logic             ir,
    input  logic             sl,
    input  logic             il,
    output logic [WIDTH-1:0] out
);

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .oc (oc),
        .a  (a),
        .b  (b),
        .f  (f)
    );

    // The if/else chain encodes the control priority directly: only the first
    // asserted control takes effect, and ir/il only matter on their own shift.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            out <= '0;
        end else if (cl) begin
            out <= '0;
        end else if (ld) begin
            out <= in;
        end else if (inc) begin
            out <= out + WIDTH'(1);
        end else if (dec) begin
            out <= out - WIDTH'(1);
        end else if (sr) begin
            out <= {ir, out[WIDTH-1:1]};
        end else if (sl) begin
            out <= {out[WIDTH-2:0], il};
        end
    end

endmodule : alu_reg_unit

// File: tb/tb_alu_reg_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_reg_unit
// Self-checking bench for alu_reg_unit (WIDTH = 4): exhaustive ALU sweep with
// spot checks, directed register sequences, then a randomized control run
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_reg_unit;
    import alu_reg_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] oc;
    logic [3:0] a, b, f;
    logic       cl, ld, inc, dec, sr, ir, sl, il;
    logic [3:0] din, dout;

    int n_pass  = 0;
    int n_total = 0;
    int model;

    alu_reg_unit #(
        .WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .oc  (oc),
        .a   (a),
        .b   (b),
        .f   (f),
        .cl  (cl),
        .ld  (ld),
        .in  (din),
        .inc (inc),
        .dec (dec),
        .sr  (sr),
        .ir  (ir),
        .sl  (sl),
        .il  (il),
        .out (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic c_cl, input logic c_ld, input logic c_inc,
                           input logic c_dec, input logic c_sr, input logic c_sl);
        cl  = c_cl;
        ld  = c_ld;
        inc = c_inc;
        dec = c_dec;
        sr  = c_sr;
        sl  = c_sl;
    endtask

    // Integer-arithmetic ALU reference, results reduced modulo 16.
    function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        int xi = int'(x);
        int yi = int'(y);
        int r  = 0;
        case (op)
            3'd0: r = (xi + yi) % 16;
            3'd1: r = (xi - yi + 16) % 16;
            3'd2: r = (xi * yi) % 16;
            3'd3: r = (yi == 0) ? 0 : xi / yi;
            3'd4: r = 15 - xi;
            3'd5: r = xi ^ yi;
            3'd6: r = xi | yi;
            3'd7: r = xi & yi;
            default: r = 0;
        endcase
        return r[3:0];
    endfunction

    initial begin
        rst = 1'b1;
        oc  = 3'b000;
        a   = 4'b0000;
        b   = 4'b0000;
        din = 4'b0000;
        ir  = 1'b0;
        il  = 1'b0;
        set_ctl(0, 0, 0, 0, 0, 0);

        // ---------------- ALU spot checks ----------------
        oc = OC_ADD; a = 4'b1111; b = 4'b0001; #1;
        check("alu_add_wrap", f, 4'b0000);
        oc = OC_SUB; a = 4'b0000; b = 4'b0001; #1;
        check("alu_sub_wrap", f, 4'b1111);
        oc = OC_MUL; a = 4'b0101; b = 4'b0011; #1;
        check("alu_mul_trunc", f, 4'b1111);
        oc = OC_DIV; a = 4'b1001; b = 4'b0000; #1;
        check("alu_div_zero", f, 4'b0000);

        // ---------------- exhaustive ALU sweep ----------------
        for (int i = 0; i < 2048; i++) begin
            logic [10:0] v;
            v = 11'(i);
            {oc, a, b} = v;
            #1;
            check($sformatf("alu_sweep oc=%b a=%b b=%b", oc, a, b), f, alu_ref(oc, a, b));
        end

        // ---------------- reset dominates load ----------------
        rst = 1'b1; din = 4'b1010; set_ctl(0, 1, 0, 0, 0, 0);
        tick();
        check("rst_edge1", dout, 4'b0000);
        tick();
        check("rst_edge2", dout, 4'b0000);
        rst = 1'b0;
        tick();
        check("rst_release_load", dout, 4'b1010);

        // ---------------- wrap ----------------
        din = 4'b1111;
        tick();
        check("load_1111", dout, 4'b1111);
        set_ctl(0, 0, 1, 0, 0, 0);
        tick();
        check("inc_wrap", dout, 4'b0000);
        set_ctl(0, 0, 0, 1, 0, 0);
        tick();
        check("dec_wrap", dout, 4'b1111);

        // ---------------- shifts ----------------
        din = 4'b1001; set_ctl(0, 1, 0, 0, 0, 0);
        tick();
        check("load_1001", dout, 4'b1001);
        ir = 1'b1; il = 1'b1; set_ctl(0, 0, 0, 0, 1, 0);
        tick();
        check("sr_ir1", dout, 4'b1100);
        ir = 1'b1; il = 1'b0; set_ctl(0, 0, 0, 0, 0, 1);
        tick();
        check("sl_il0", dout, 4'b1000);
        il = 1'b1;
        tick();
        check("sl_il1", dout, 4'b0001);

        // ---------------- priority ----------------
        din = 4'b0110; set_ctl(0, 1, 0, 0, 0, 0);
        tick();
        check("load_0110", dout, 4'b0110);
        set_ctl(1, 1, 1, 0, 0, 0);
        tick();
        check("prio_cl", dout, 4'b0000);
        din = 4'b0011; set_ctl(0, 1, 1, 1, 0, 0);
        tick();
        check("prio_ld", dout, 4'b0011);
        set_ctl(0, 0, 1, 1, 1, 0);
        tick();
        check("prio_inc", dout, 4'b0100);
        ir = 1'b0; set_ctl(0, 0, 0, 1, 1, 1);
        tick();
        check("prio_dec", dout, 4'b0011);
        ir = 1'b1; set_ctl(0, 0, 0, 0, 1, 1);
        tick();
        check("prio_sr", dout, 4'b1001);

        // ---------------- hold ----------------
        set_ctl(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("hold", dout, 4'b1001);

        // ---------------- mid-sequence reset ----------------
        set_ctl(0, 0, 1, 0, 0, 0); rst = 1'b1;
        tick();
        check("mid_rst", dout, 4'b0000);
        rst = 1'b0;
        tick();
        check("mid_rst_resume", dout, 4'b0001);

        // ---------------- random control run ----------------
        model = 1;
        for (int c = 0; c < 1000; c++) begin
            set_ctl($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            din = 4'($urandom_range(0, 15));
            ir  = 1'($urandom_range(0, 1));
            il  = 1'($urandom_range(0, 1));
            if (cl)       model = 0;
            else if (ld)  model = int'(din);
            else if (inc) model = (model + 1) % 16;
            else if (dec) model = (model + 15) % 16;
            else if (sr)  model = (ir ? 8 : 0) + model / 2;
            else if (sl)  model = (model * 2) % 16 + (il ? 1 : 0);
            tick();
            check($sformatf("rand cyc=%0d", c), dout, 4'(model));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_alu_reg_unit
